// File: rtl/argmax_sequencer_pkg.sv
// argmax_sequencer_pkg: shared sizes, state encoding and buffer slot helper
package argmax_sequencer_pkg;
    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 26;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int slot_off(input int i);
        return i * SCORE_W;
    endfunction
endpackage

// File: rtl/argmax_sequencer_if.sv
// argmax_sequencer_if: score stream in, classification result out
interface argmax_sequencer_if;
    import argmax_sequencer_pkg::*;

    logic                              clear;
    logic signed [SCORE_W-1:0]         score_in;
    logic                              score_valid;
    logic                              score_ready;
    logic                              result_ack;
    logic                              result_valid;
    logic [IDX_W-1:0]                  result_index;
    logic signed [SCORE_W-1:0]         result_max;
    logic                              busy;
    logic [NUM_CLASSES*SCORE_W-1:0]    scores_packed;

    modport slave (
        input  clear, score_in, score_valid, result_ack,
        output score_ready, result_valid, result_index, result_max, busy, scores_packed
    );

    modport master (
        output clear, score_in, score_valid, result_ack,
        input  score_ready, result_valid, result_index, result_max, busy, scores_packed
    );
endinterface

// File: rtl/argmax_compare_stage.sv
// argmax_compare_stage: one strict signed greater-than step; ties keep the incumbent
module argmax_compare_stage
    import argmax_sequencer_pkg::*;
(
    input  logic signed [SCORE_W-1:0] best_val_i,
    input  logic [IDX_W-1:0]          best_idx_i,
    input  logic signed [SCORE_W-1:0] cand_val_i,
    input  logic [IDX_W-1:0]          cand_idx_i,
    output logic signed [SCORE_W-1:0] best_val_o,
    output logic [IDX_W-1:0]          best_idx_o
);
    logic take;

    assign take       = cand_val_i > best_val_i;
    assign best_val_o = take ? cand_val_i : best_val_i;
    assign best_idx_o = take ? cand_idx_i : best_idx_i;
endmodule

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: buffers serial class scores, scans for the maximum, holds result until ack
module argmax_sequencer
    import argmax_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           GlobalReset,
    argmax_sequencer_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

    state_e                    state_q;
    logic [IDX_W-1:0]          load_cnt_q;
    logic [IDX_W-1:0]          scan_idx_q;
    logic signed [SCORE_W-1:0] score_buf_q [NUM_CLASSES];
    logic [IDX_W-1:0]          best_idx_q;
    logic signed [SCORE_W-1:0] best_val_q;
    logic [IDX_W-1:0]          result_index_q;
    logic signed [SCORE_W-1:0] result_max_q;
    logic                      result_valid_q;
    logic                      busy_q;
    logic [IDX_W-1:0]          best_idx_d;
    logic signed [SCORE_W-1:0] best_val_d;

    argmax_compare_stage u_cmp (
        .best_val_i (best_val_q),
        .best_idx_i (best_idx_q),
        .cand_val_i (score_buf_q[scan_idx_q]),
        .cand_idx_i (scan_idx_q),
        .best_val_o (best_val_d),
        .best_idx_o (best_idx_d)
    );

    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_pack
        assign bus.scores_packed[slot_off(i) +: SCORE_W] = score_buf_q[i];
    end

    assign bus.score_ready  = state_q == LOAD;
    assign bus.result_valid = result_valid_q;
    assign bus.result_index = result_index_q;
    assign bus.result_max   = result_max_q;
    assign bus.busy         = busy_q;

    // Load / scan / hold sequencer; clear aborts to LOAD but keeps buffer and last result
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q        <= LOAD;
            load_cnt_q     <= '0;
            scan_idx_q     <= '0;
            best_idx_q     <= '0;
            best_val_q     <= '0;
            result_index_q <= '0;
            result_max_q   <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) score_buf_q[i] <= '0;
        end else if (bus.clear) begin
            state_q        <= LOAD;
            load_cnt_q     <= '0;
            scan_idx_q     <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                LOAD: if (bus.score_valid) begin
                    score_buf_q[load_cnt_q] <= bus.score_in;
                    if (load_cnt_q == LAST) begin
                        state_q    <= SCAN;
                        load_cnt_q <= '0;
                        scan_idx_q <= IDX_W'(1);
                        best_idx_q <= '0;
                        best_val_q <= score_buf_q[0];
                        busy_q     <= 1'b1;
                    end else begin
                        load_cnt_q <= load_cnt_q + 1'b1;
                    end
                end
                SCAN: begin
                    best_idx_q <= best_idx_d;
                    best_val_q <= best_val_d;
                    if (scan_idx_q == LAST) begin
                        state_q        <= DONE;
                        scan_idx_q     <= '0;
                        result_index_q <= best_idx_d;
                        result_max_q   <= best_val_d;
                        result_valid_q <= 1'b1;
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                DONE: if (bus.result_ack) begin
                    state_q        <= LOAD;
                    load_cnt_q     <= '0;
                    result_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
                default: state_q <= LOAD;
            endcase
        end
    end
endmodule
